// File: rtl/sync_pulse_generator.sv
// Programmable sync pulse transmitter: periodic pulse of configurable period/width in prescaled ticks.
// Optional SYNC_GEN_GLITCHLESS_POL_EN: polarity re-sampled only in IDLE and at period boundaries.
module sync_pulse_generator #(
    parameter int unsigned PRESCALE = 50,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             positive_polarity_in,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic             cfg_load,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             busy,
    output logic             frame_start,
    output logic             sync_out
);
    localparam int unsigned      PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(64);
    localparam logic [CNT_W-1:0] RST_WIDTH  = CNT_W'(5);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] period_q, period_d, width_q, width_d;
    logic [CNT_W-1:0] pend_period_q, pend_period_d, pend_width_q, pend_width_d;
    logic             pend_valid_q, pend_valid_d;
    logic             pol_q, pol_d;
    logic             sync_q, sync_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             fs_q, fs_d;
    logic             tick, load_valid, boundary, apply, active_d;

    assign tick       = (presc_q == PRESC_LAST);
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign load_valid = (cfg_period >= CNT_W'(2)) && (cfg_width != '0) && (cfg_width < cfg_period);
    assign boundary   = (state_q == GAP) && tick && (cnt_inc == period_q);
    assign apply      = pend_valid_q && ((state_q == IDLE) || boundary);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fs_d     = 1'b0;
        active_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = PULSE;
                    cnt_d    = '0;
                    fs_d     = 1'b1;
                    active_d = 1'b1;
                end
            end
            PULSE: begin
                active_d = 1'b1;
                if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == width_q) begin
                        state_d  = GAP;
                        active_d = 1'b0;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (cnt_inc == period_q) begin
                        cnt_d = '0;
                        if (enable) begin
                            state_d  = PULSE;
                            fs_d     = 1'b1;
                            active_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign presc_d = ((state_q == IDLE) || tick) ? '0 : presc_q + PW'(1);

    // A load on the applying clk becomes the next pending config, since apply uses the old pending.
    always_comb begin
        period_d      = period_q;
        width_d       = width_q;
        pend_period_d = pend_period_q;
        pend_width_d  = pend_width_q;
        pend_valid_d  = pend_valid_q;
        err_d         = err_q;
        ack_d         = apply;
        if (apply) begin
            period_d     = pend_period_q;
            width_d      = pend_width_q;
            pend_valid_d = 1'b0;
        end
        if (cfg_load) begin
            if (load_valid) begin
                pend_period_d = cfg_period;
                pend_width_d  = cfg_width;
                pend_valid_d  = 1'b1;
                err_d         = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

`ifdef SYNC_GEN_GLITCHLESS_POL_EN
    assign pol_d = ((state_q == IDLE) || boundary) ? positive_polarity_in : pol_q;
`else
    assign pol_d = positive_polarity_in;
`endif

    assign sync_d = active_d ? pol_d : ~pol_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            presc_q       <= '0;
            cnt_q         <= '0;
            period_q      <= RST_PERIOD;
            width_q       <= RST_WIDTH;
            pend_period_q <= '0;
            pend_width_q  <= '0;
            pend_valid_q  <= 1'b0;
            pol_q         <= 1'b0;
            sync_q        <= 1'b1;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            fs_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            width_q       <= width_d;
            pend_period_q <= pend_period_d;
            pend_width_q  <= pend_width_d;
            pend_valid_q  <= pend_valid_d;
            pol_q         <= pol_d;
            sync_q        <= sync_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            fs_q          <= fs_d;
        end
    end

    assign cfg_ack     = ack_q;
    assign cfg_err     = err_q;
    assign busy        = (state_q != IDLE);
    assign frame_start = fs_q;
    assign sync_out    = sync_q;
endmodule

// File: tb/tb_sync_pulse_generator.sv
// Self-checking bench for sync_pulse_generator: directed scenarios plus randomized traffic
// against a time-based behavioural model (frame position measured in clks since frame start).
`timescale 1ns/1ps
module tb_sync_pulse_generator;
    localparam int P = 2;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1, enable = 1'b0, pol_in = 1'b0, cfg_load = 1'b0;
    logic [W-1:0] cfg_period = '0, cfg_width = '0;
    logic         cfg_ack, cfg_err, busy, frame_start, sync_out;

    always #5 clk = ~clk;

    sync_pulse_generator #(.PRESCALE(P), .CNT_W(W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .positive_polarity_in(pol_in),
        .cfg_period(cfg_period), .cfg_width(cfg_width), .cfg_load(cfg_load),
        .cfg_ack(cfg_ack), .cfg_err(cfg_err), .busy(busy),
        .frame_start(frame_start), .sync_out(sync_out)
    );

    int n_checks = 0, n_pass = 0, cyc = 0;

    // reference model state
    bit m_run, m_sync, m_fs, m_ack, m_err, m_pv, m_pol;
    int m_t, m_per, m_wid, m_pp, m_pw;

    logic [4:0] dut_v, exp_v;
    assign dut_v = {sync_out, frame_start, cfg_ack, cfg_err, busy};
    assign exp_v = {m_sync, m_fs, m_ack, m_err, m_run};

    // observation logs
    int fs_log[$], ack_log[$], hi_log[$], lo_log[$];
    int mm, mm_cyc, edge_cyc;
    logic [4:0] mm_got, mm_exp;
    logic prev_sync;

    task automatic step();
        bit idle, bnd, lv;
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_run = 0; m_t = 0; m_per = 64; m_wid = 5; m_pv = 0;
            m_pol = 0; m_sync = 1; m_ack = 0; m_err = 0; m_fs = 0;
        end else begin
            idle  = !m_run;
            bnd   = m_run && (m_t + 1 == m_per * P);
            m_ack = m_pv && (idle || bnd);
            if (m_ack) begin m_per = m_pp; m_wid = m_pw; m_pv = 0; end
`ifdef SYNC_GEN_GLITCHLESS_POL_EN
            if (idle || bnd) m_pol = pol_in;
`else
            m_pol = pol_in;
`endif
            if (cfg_load) begin
                lv = (int'(cfg_period) >= 2) && (int'(cfg_width) >= 1) && (cfg_width < cfg_period);
                if (lv) begin m_pp = cfg_period; m_pw = cfg_width; m_pv = 1; m_err = 0; end
                else m_err = 1;
            end
            if (idle || bnd) begin m_run = enable; m_fs = enable; m_t = 0; end
            else begin m_fs = 0; m_t++; end
            m_sync = (m_run && m_t < m_wid * P) ? m_pol : !m_pol;
        end
        @(negedge clk);
    endtask

    task automatic clear_obs();
        fs_log.delete(); ack_log.delete(); hi_log.delete(); lo_log.delete();
        mm = 0; edge_cyc = -1; prev_sync = sync_out;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            if (dut_v !== exp_v) begin
                if (mm == 0) begin mm_cyc = cyc; mm_got = dut_v; mm_exp = exp_v; end
                mm++;
            end
            if (frame_start === 1'b1) fs_log.push_back(cyc);
            if (cfg_ack === 1'b1) ack_log.push_back(cyc);
            if (sync_out !== prev_sync) begin
                if (edge_cyc >= 0) begin
                    if (prev_sync === 1'b1) hi_log.push_back(cyc - edge_cyc);
                    else lo_log.push_back(cyc - edge_cyc);
                end
                edge_cyc = cyc;
            end
            prev_sync = sync_out;
        end
    endtask

    task automatic load(input int per, input int wid);
        cfg_period = W'(per); cfg_width = W'(wid); cfg_load = 1'b1;
        run(1);
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        int rel;
        reset = 1; enable = 1; pol_in = 1;
        repeat (3) begin
            step();
            n_checks++;
            if (dut_v !== 5'b10000) $display("FAIL reset_vals got=%b exp=%b", dut_v, 5'b10000);
            else n_pass++;
        end
        clear_obs();
        reset = 0; rel = cyc;
        run(400);
        n_checks++; if (mm !== 0) $display("FAIL reset_trace mism=%0d cyc=%0d got=%b exp=%b", mm, mm_cyc, mm_got, mm_exp); else n_pass++;
        n_checks++; if (fs_log.size() < 3) $display("FAIL reset_fs_count got=%0d exp>=3", fs_log.size()); else n_pass++;
        n_checks++; if (fs_log[0] !== rel + 1) $display("FAIL enable_latency got=%0d exp=%0d", fs_log[0], rel + 1); else n_pass++;
        n_checks++; if (fs_log[1] - fs_log[0] !== 128) $display("FAIL reset_period got=%0d exp=128", fs_log[1] - fs_log[0]); else n_pass++;
        n_checks++; if (fs_log[2] - fs_log[1] !== 128) $display("FAIL reset_period2 got=%0d exp=128", fs_log[2] - fs_log[1]); else n_pass++;
        n_checks++; if (hi_log[0] !== 10) $display("FAIL reset_high got=%0d exp=10", hi_log[0]); else n_pass++;
        n_checks++; if (lo_log[0] !== 118) $display("FAIL reset_low got=%0d exp=118", lo_log[0]); else n_pass++;
    endtask

    task automatic test_cfg_midframe();
        clear_obs();
        load(10, 3);
        run(300);
        n_checks++; if (mm !== 0) $display("FAIL mid_trace mism=%0d cyc=%0d got=%b exp=%b", mm, mm_cyc, mm_got, mm_exp); else n_pass++;
        n_checks++; if (ack_log.size() !== 1) $display("FAIL mid_ack_count got=%0d exp=1", ack_log.size()); else n_pass++;
        n_checks++; if (ack_log[0] !== fs_log[0]) $display("FAIL mid_ack_align ack=%0d exp_fs=%0d", ack_log[0], fs_log[0]); else n_pass++;
        n_checks++; if (fs_log[1] - fs_log[0] !== 20) $display("FAIL mid_period got=%0d exp=20", fs_log[1] - fs_log[0]); else n_pass++;
        n_checks++; if (hi_log[0] !== 6) $display("FAIL mid_high got=%0d exp=6", hi_log[0]); else n_pass++;
        n_checks++; if (lo_log[0] !== 14) $display("FAIL mid_low got=%0d exp=14", lo_log[0]); else n_pass++;
    endtask

    task automatic test_invalid_load();
        clear_obs();
        load(10, 10);
        n_checks++; if (cfg_err !== 1'b1) $display("FAIL inv_err_set got=%b exp=1", cfg_err); else n_pass++;
        run(100);
        n_checks++; if (mm !== 0) $display("FAIL inv_trace mism=%0d cyc=%0d got=%b exp=%b", mm, mm_cyc, mm_got, mm_exp); else n_pass++;
        n_checks++; if (fs_log[1] - fs_log[0] !== 20) $display("FAIL inv_period got=%0d exp=20", fs_log[1] - fs_log[0]); else n_pass++;
        n_checks++; if (ack_log.size() !== 0) $display("FAIL inv_no_ack got=%0d exp=0", ack_log.size()); else n_pass++;
        load(8, 2);
        n_checks++; if (cfg_err !== 1'b0) $display("FAIL inv_err_clear got=%b exp=0", cfg_err); else n_pass++;
        run(60);
    endtask

    task automatic test_enable_drop();
        int fs0, fall;
        reset = 1; run(2);
        reset = 0; enable = 1; pol_in = 1;
        run(1);
        fs0 = cyc;
        n_checks++; if (frame_start !== 1'b1) $display("FAIL drop_start got=%b exp=1", frame_start); else n_pass++;
        run(2 * P);
        enable = 0;
        clear_obs();
        fall = -1;
        for (int i = 0; i < 300 && fall < 0; i++) begin
            run(1);
            if (busy === 1'b0) fall = cyc;
        end
        n_checks++; if (fall - fs0 !== 128) $display("FAIL drop_busy_fall got=%0d exp=128", fall - fs0); else n_pass++;
        n_checks++; if (fs_log.size() !== 0) $display("FAIL drop_no_fs got=%0d exp=0", fs_log.size()); else n_pass++;
        n_checks++; if (mm !== 0) $display("FAIL drop_trace mism=%0d cyc=%0d got=%b exp=%b", mm, mm_cyc, mm_got, mm_exp); else n_pass++;
        run(10);
    endtask

    task automatic test_pol_flip();
        int fs0;
        logic exp_s;
        reset = 1; pol_in = 0; run(2);
        reset = 0; enable = 1;
        run(1); fs0 = cyc;
        run(3);
        pol_in = 1;
        clear_obs();
        run(1);
`ifdef SYNC_GEN_GLITCHLESS_POL_EN
        exp_s = 1'b0;
`else
        exp_s = 1'b1;
`endif
        n_checks++; if (sync_out !== exp_s) $display("FAIL pol_flip got=%b exp=%b", sync_out, exp_s); else n_pass++;
        run(200);
        n_checks++; if (fs_log[0] !== fs0 + 128) $display("FAIL pol_next_fs got=%0d exp=%0d", fs_log[0], fs0 + 128); else n_pass++;
        n_checks++; if (mm !== 0) $display("FAIL pol_trace mism=%0d cyc=%0d got=%b exp=%b", mm, mm_cyc, mm_got, mm_exp); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            run(1);
            if (frame_start === 1'b1) hit = 1;
        end
        n_checks++; if (!hit) $display("FAIL rmid_wait_fs got=timeout exp=frame_start"); else n_pass++;
        run(2);
        load(10, 3);
        reset = 1;
        run(1);
        n_checks++; if (dut_v !== 5'b10000) $display("FAIL rmid_vals got=%b exp=%b", dut_v, 5'b10000); else n_pass++;
        reset = 0;
        clear_obs();
        run(300);
        n_checks++; if (fs_log[1] - fs_log[0] !== 128) $display("FAIL rmid_period got=%0d exp=128", fs_log[1] - fs_log[0]); else n_pass++;
        n_checks++; if (ack_log.size() !== 0) $display("FAIL rmid_pending_dropped acks=%0d exp=0", ack_log.size()); else n_pass++;
        n_checks++; if (mm !== 0) $display("FAIL rmid_trace mism=%0d cyc=%0d got=%b exp=%b", mm, mm_cyc, mm_got, mm_exp); else n_pass++;
    endtask

    task automatic test_boundary_load();
        bit hit = 0;
        int bcyc;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (m_run && (m_t + 1 == m_per * P)) hit = 1;
            else run(1);
        end
        n_checks++; if (!hit) $display("FAIL bnd_wait got=timeout exp=boundary"); else n_pass++;
        load(6, 2);
        bcyc = cyc;
        n_checks++; if ({frame_start, cfg_ack} !== 2'b10) $display("FAIL bnd_no_apply got=%b exp=10", {frame_start, cfg_ack}); else n_pass++;
        clear_obs();
        run(300);
        n_checks++; if (ack_log[0] - bcyc !== 128) $display("FAIL bnd_ack_next got=%0d exp=128", ack_log[0] - bcyc); else n_pass++;
        n_checks++; if (fs_log[1] - fs_log[0] !== 12) $display("FAIL bnd_new_period got=%0d exp=12", fs_log[1] - fs_log[0]); else n_pass++;
        n_checks++; if (mm !== 0) $display("FAIL bnd_trace mism=%0d cyc=%0d got=%b exp=%b", mm, mm_cyc, mm_got, mm_exp); else n_pass++;
    endtask

    task automatic test_back_to_back();
        run(3);
        clear_obs();
        load(9, 4);
        load(7, 1);
        run(100);
        n_checks++; if (ack_log.size() !== 1) $display("FAIL b2b_ack_count got=%0d exp=1", ack_log.size()); else n_pass++;
        n_checks++; if (fs_log[2] - fs_log[1] !== 14) $display("FAIL b2b_last_wins got=%0d exp=14", fs_log[2] - fs_log[1]); else n_pass++;
        n_checks++; if (hi_log[hi_log.size() - 1] !== 2) $display("FAIL b2b_high got=%0d exp=2", hi_log[hi_log.size() - 1]); else n_pass++;
        n_checks++; if (mm !== 0) $display("FAIL b2b_trace mism=%0d cyc=%0d got=%b exp=%b", mm, mm_cyc, mm_got, mm_exp); else n_pass++;
    endtask

    task automatic test_random();
        clear_obs();
        for (int i = 0; i < 3000; i++) begin
            cfg_load   = ($urandom_range(0, 29) == 0);
            cfg_period = W'($urandom_range(0, 16));
            cfg_width  = W'($urandom_range(0, 17));
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            if ($urandom_range(0, 99) == 0) pol_in = ~pol_in;
            reset = ($urandom_range(0, 999) == 0);
            run(1);
        end
        cfg_load = 0; reset = 0;
        n_checks++; if (mm !== 0) $display("FAIL rand_trace mism=%0d cyc=%0d got=%b exp=%b", mm, mm_cyc, mm_got, mm_exp); else n_pass++;
        n_checks++; if (fs_log.size() == 0) $display("FAIL rand_activity frames=%0d exp>0", fs_log.size()); else n_pass++;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cfg_midframe();
        test_invalid_load();
        test_enable_drop();
        test_pol_flip();
        test_reset_mid();
        test_boundary_load();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
